// File: rtl/riscv_pkg.sv
// Shared RISC-V integer-pipeline constants and types used by the write-back stage.
package riscv_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read, one-write integer register file with x0 hardwired to zero.
// Build option WB_REGFILE_BYPASS_EN adds a write-through path to both read ports.
module regfile_2r1w
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = 32,
    parameter int AW   = riscv_pkg::REG_AW
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    import riscv_pkg::*;

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != AW'(REG_ZERO))) begin
            regs[waddr] <= wdata;
        end
    end

    // x0 reads are masked rather than relying on the array entry staying zero.
    always_comb begin
        rdata1 = (raddr1 == AW'(REG_ZERO)) ? '0 : regs[raddr1];
        rdata2 = (raddr2 == AW'(REG_ZERO)) ? '0 : regs[raddr2];
`ifdef WB_REGFILE_BYPASS_EN
        if (we && (waddr != AW'(REG_ZERO)) && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end
        if (we && (waddr != AW'(REG_ZERO)) && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end
`endif
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, register-file commit, retire trace and commit counter.
// Optional macro WB_REGFILE_BYPASS_EN enables same-cycle write-through on the read ports.
module wb_regfile
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREG  = 32,
    parameter int AW    = riscv_pkg::REG_AW,
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             memtoreg,
    input  logic             regwrite,
    input  logic [AW-1:0]    rd,
    input  logic [XLEN-1:0]  readdata,
    input  logic [XLEN-1:0]  result_alu,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic [XLEN-1:0]  wb_data,
    output logic             trace_valid,
    output logic [AW-1:0]    trace_rd,
    output logic [XLEN-1:0]  trace_data,
    output logic [CNT_W-1:0] wb_count
);
    import riscv_pkg::*;

    logic commit;

    assign wb_data = memtoreg ? readdata : result_alu;
    // Gating with reset keeps a commit presented during reset from reaching the bypass path.
    assign commit  = regwrite && (rd != AW'(REG_ZERO)) && reset;

    regfile_2r1w #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_regs (
        .clk    (clk),
        .reset  (reset),
        .we     (commit),
        .waddr  (rd),
        .wdata  (wb_data),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            trace_valid <= 1'b0;
            trace_rd    <= '0;
            trace_data  <= '0;
            wb_count    <= '0;
        end else if (commit) begin
            trace_valid <= 1'b1;
            trace_rd    <= rd;
            trace_data  <= wb_data;
            wb_count    <= wb_count + 1'b1;
        end else begin
            trace_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a second instance with a 4-bit counter covers wrap.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        memtoreg;
    logic        regwrite;
    logic [4:0]  rd;
    logic [63:0] readdata;
    logic [63:0] result_alu;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;

    logic [63:0] rs1_data, rs2_data, wb_data, trace_data;
    logic        trace_valid;
    logic [4:0]  trace_rd;
    logic [31:0] wb_count;

    logic [63:0] s_rs1_data, s_rs2_data, s_wb_data, s_trace_data;
    logic        s_trace_valid;
    logic [4:0]  s_trace_rd;
    logic [3:0]  s_wb_count;

    int total = 0;
    int bad   = 0;

    wb_regfile dut (
        .clk(clk), .reset(reset), .memtoreg(memtoreg), .regwrite(regwrite), .rd(rd),
        .readdata(readdata), .result_alu(result_alu), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data), .trace_valid(trace_valid),
        .trace_rd(trace_rd), .trace_data(trace_data), .wb_count(wb_count)
    );

    wb_regfile #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .memtoreg(memtoreg), .regwrite(regwrite), .rd(rd),
        .readdata(readdata), .result_alu(result_alu), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(s_rs1_data), .rs2_data(s_rs2_data), .wb_data(s_wb_data), .trace_valid(s_trace_valid),
        .trace_rd(s_trace_rd), .trace_data(s_trace_data), .wb_count(s_wb_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // one-cycle write-back; returns at the negedge after the commit edge
    task automatic commit(input logic [4:0] a, input logic mem_sel,
                          input logic [63:0] alu, input logic [63:0] mem);
        regwrite   = 1'b1;
        memtoreg   = mem_sel;
        rd         = a;
        result_alu = alu;
        readdata   = mem;
        step();
        regwrite   = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [63:0] exp);
        rs1_addr = a;
        #1;
        check(tag, rs1_data, exp);
    endtask

    initial begin
        reset = 1'b0; memtoreg = 1'b0; regwrite = 1'b0; rd = '0;
        readdata = '0; result_alu = '0; rs1_addr = '0; rs2_addr = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // every register reads zero after reset
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            check($sformatf("rst_rs1_%0d", i), rs1_data, 64'h0);
            check($sformatf("rst_rs2_%0d", 31 - i), rs2_data, 64'h0);
        end
        check("rst_count", 64'(wb_count), 64'd0);
        check("rst_tvalid", 64'(trace_valid), 64'd0);
        check("rst_trd", 64'(trace_rd), 64'd0);
        check("rst_tdata", trace_data, 64'd0);

        // ALU write-back
        regwrite = 1'b1; memtoreg = 1'b0; rd = 5'd5; result_alu = 64'h1234; readdata = 64'h9999;
        #1;
        check("alu_wbdata", wb_data, 64'h1234);
        commit(5'd5, 1'b0, 64'h1234, 64'h9999);
        read_chk("alu_rd5", 5'd5, 64'h1234);
        check("alu_tvalid", 64'(trace_valid), 64'd1);
        check("alu_trd", 64'(trace_rd), 64'd5);
        check("alu_tdata", trace_data, 64'h1234);
        check("alu_count", 64'(wb_count), 64'd1);

        // load write-back
        regwrite = 1'b1; memtoreg = 1'b1; rd = 5'd6; result_alu = 64'h99; readdata = 64'hDEADBEEF;
        #1;
        check("ld_wbdata", wb_data, 64'hDEADBEEF);
        commit(5'd6, 1'b1, 64'h99, 64'hDEADBEEF);
        read_chk("ld_rd6", 5'd6, 64'hDEADBEEF);
        read_chk("ld_rd5_kept", 5'd5, 64'h1234);
        check("ld_count", 64'(wb_count), 64'd2);
        check("ld_tdata", trace_data, 64'hDEADBEEF);

        // idle cycle: trace_valid drops, trace fields hold
        step();
        check("idle_tvalid", 64'(trace_valid), 64'd0);
        check("idle_trd", 64'(trace_rd), 64'd6);
        check("idle_tdata", trace_data, 64'hDEADBEEF);

        // x0 protection
        commit(5'd0, 1'b0, 64'hFFFF, 64'h0);
        read_chk("x0_read", 5'd0, 64'h0);
        check("x0_count", 64'(wb_count), 64'd2);
        check("x0_tvalid", 64'(trace_valid), 64'd0);
        check("x0_trd", 64'(trace_rd), 64'd6);

        // same-cycle read of the register being written
        regwrite = 1'b1; memtoreg = 1'b0; rd = 5'd7; result_alu = 64'hAA; rs2_addr = 5'd7; rs1_addr = 5'd0;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check("same_rs2", rs2_data, 64'hAA);
`else
        check("same_rs2", rs2_data, 64'h0);
`endif
        check("same_rs1_x0", rs1_data, 64'h0);
        step();
        regwrite = 1'b0;
        #1;
        check("next_rs2", rs2_data, 64'hAA);

        // reset wins over a simultaneous commit
        commit(5'd3, 1'b0, 64'h55, 64'h0);
        read_chk("pre_rd3", 5'd3, 64'h55);
        reset = 1'b0; regwrite = 1'b1; memtoreg = 1'b0; rd = 5'd3; result_alu = 64'h77;
        rs2_addr = 5'd3;
        #1;
        check("rstpri_rs2_nobyp", rs2_data, 64'h55);
        step();
        reset = 1'b1; regwrite = 1'b0;
        read_chk("rstpri_rd3", 5'd3, 64'h0);
        read_chk("rstpri_rd6", 5'd6, 64'h0);
        check("rstpri_count", 64'(wb_count), 64'd0);
        check("rstpri_tvalid", 64'(trace_valid), 64'd0);
        check("rstpri_trd", 64'(trace_rd), 64'd0);
        check("rstpri_tdata", trace_data, 64'd0);
        commit(5'd9, 1'b0, 64'h4242, 64'h0);
        check("post_rst_count", 64'(wb_count), 64'd1);
        read_chk("post_rst_rd9", 5'd9, 64'h4242);

        // counter wrap: 17 back-to-back commits to x1
        reset = 1'b0;
        step();
        reset = 1'b1;
        regwrite = 1'b1; memtoreg = 1'b0; rd = 5'd1;
        for (int i = 1; i <= 17; i++) begin
            result_alu = 64'h100 + 64'(i);
            step();
        end
        regwrite = 1'b0;
        check("wrap_small_count", 64'(s_wb_count), 64'd1);
        check("wrap_big_count", 64'(wb_count), 64'd17);
        read_chk("wrap_rd1", 5'd1, 64'h111);
        check("wrap_small_rd1", s_rs1_data, 64'h111);
        check("wrap_tdata", trace_data, 64'h111);
        check("wrap_tvalid", 64'(trace_valid), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the 5-stage RISC-V pipeline; consumes the MEM/WB pipeline-register outputs.
- Selects the write-back value (memory load data or ALU result) and commits it to a 32 x 64-bit integer register file.
- Provides the two decode-stage read ports and a registered retire trace for the bench and debug.
- Counts committed register writes.

Parameters:
- XLEN, 64, data width of registers and write-back values
- NREG, 32, number of architectural registers; x0 is hardwired to zero
- AW, 5, register address width (log2 NREG)
- CNT_W, 32, width of the write-commit counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- memtoreg  input  1  from MEM/WB: 1 selects readdata, 0 selects result_alu
- regwrite  input  1  from MEM/WB: write-back enable
- rd  input  AW  from MEM/WB: destination register
- readdata  input  XLEN  from MEM/WB: data memory load value
- result_alu  input  XLEN  from MEM/WB: ALU result
- rs1_addr  input  AW  decode read port 1 address
- rs2_addr  input  AW  decode read port 2 address
- rs1_data  output  XLEN  read port 1 data (combinational)
- rs2_data  output  XLEN  read port 2 data (combinational)
- wb_data  output  XLEN  selected write-back value (combinational), feeds the forwarding unit
- trace_valid  output  1  registered: a commit occurred on the previous edge
- trace_rd  output  AW  registered: register written on that commit
- trace_data  output  XLEN  registered: value written on that commit
- wb_count  output  CNT_W  registered: number of committed writes since reset

Behaviour:
- Write-back mux: wb_data = memtoreg ? readdata : result_alu. Purely combinational, valid whenever the inputs are.
- Commit condition: commit = regwrite && (rd != 0) && (reset == 1).
- On a rising edge with commit:
  - regs[rd] <= wb_data.
  - trace_valid <= 1; trace_rd <= rd; trace_data <= wb_data.
  - wb_count <= wb_count + 1, wrapping modulo 2^CNT_W with no saturation or flag.
- On a rising edge without commit: registers and wb_count hold; trace_valid <= 0; trace_rd and trace_data hold their last values.
- regwrite=1 with rd=0 is discarded: no array change, trace_valid=0, counter unchanged.
- Reset (reset==0 at a rising edge):
  - All NREG registers <= 0; trace_valid <= 0; trace_rd <= 0; trace_data <= 0; wb_count <= 0.
  - Reset has priority: a commit presented in the same cycle is dropped.
  - Reset asserted mid-stream takes effect at that edge; the first commit after release is counted as 1.
- Reads: rsN_data = 0 when rsN_addr == 0, else regs[rsN_addr]. Both ports are independent and may address the same register.
- After the first reset edge every read returns 0 until a commit occurs.
- Latency: a written value is visible on the read ports the cycle after the commit edge (or the same cycle when the optional bypass is enabled). Trace outputs lag the commit edge by 0 cycles, i.e. they are updated by that edge.
- No handshake or back-pressure: write-back always completes in one cycle.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: write-through bypass. If commit is true and rsN_addr == rd (nonzero), rsN_data = wb_data in the same cycle. This resolves the WB-to-ID hazard without a half-cycle register file.
- Undefined: read ports return only the stored array value. The hazard unit must stall or forward for one cycle.
- x0 is never bypassed in either build.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and REG_AW constants.
  - reg_addr_t (AW bits) and xlen_t (XLEN bits) typedefs.
  - REG_ZERO constant = 0.
- Sub-module regfile_2r1w: array, synchronous reset clear, x0 masking, optional bypass.
- Top wb_regfile contains the write-back mux, commit logic, trace registers and counter.

Test Plan:
- Reset check: hold reset=0 for 2 edges, then release. Required: rs1_data=rs2_data=0 for all addresses, wb_count=0, trace_valid=0.
- ALU and load write-back:
  - regwrite=1, memtoreg=0, rd=5, result_alu=0x1234 -> next cycle rs1_addr=5 gives 0x1234; trace_rd=5, trace_data=0x1234, wb_count=1.
  - Then memtoreg=1, rd=6, readdata=0xDEADBEEF -> regs[6]=0xDEADBEEF, wb_count=2.
- x0 protection: regwrite=1, rd=0, result_alu=0xFFFF -> rs1_addr=0 reads 0; wb_count unchanged; trace_valid=0.
- Same-cycle read of the register being written: rd=7, result_alu=0xAA, rs2_addr=7 in the commit cycle.
  - Bypass build: rs2_data=0xAA in that cycle.
  - Non-bypass build: rs2_data holds the old value (0), then reads 0xAA next cycle.
- Reset priority: regs[3]=0x55, then reset=0 in the same cycle as regwrite=1, rd=3, result_alu=0x77 -> regs[3]=0, wb_count=0, trace_valid=0.
- Counter wrap (CNT_W=4 override): 17 consecutive commits to rd=1 -> wb_count=1; regs[1] holds the 17th value.
